// File: rtl/quadrature_encoder_reader_if.sv
// Avalon-MM control port bundle for the quadrature encoder reader.
// The CPU side (master) drives address/strobes/write data; the block
// (slave) returns registered read data and a waitrequest that never stalls.
interface quadrature_encoder_reader_if;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  byteenable;
    logic [2:0]  address;
    logic        write;
    logic        read;
    logic        waitrequest;

    modport master (
        output writedata, byteenable, address, write, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  writedata, byteenable, address, write, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/quadrature_encoder_reader.sv
// Quadrature encoder reader: A/B/Z inputs are synchronised and glitch
// filtered, then decoded into a signed position count.  The block also
// provides a windowed velocity measurement, index capture, and illegal
// transition tracking, all exposed through an Avalon-MM register slave.
module quadrature_encoder_reader #(
    parameter int FILTER_LEN = 4
) (
    input  logic                              csi_MCLK_clk,
    input  logic                              rsi_MRST_reset,
    quadrature_encoder_reader_if.slave        avs_ctrl,
    input  logic                              enc_a,
    input  logic                              enc_b,
    input  logic                              enc_z
);

    // The filter commits on the cycle where the counter already holds
    // FILTER_LEN-1 mismatches, so that cycle is the FILTER_LEN-th mismatch.
    localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

    // Bit order for all per-channel vectors: [0]=A, [1]=B, [2]=Z.
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] filt_q, filt_d;
    logic [2:0] prev_q, prev_d;
    logic [7:0] fcnt_q [3];
    logic [7:0] fcnt_d [3];

    logic signed [31:0] position_q, position_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic               idx_seen_q, idx_seen_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic signed [31:0] velocity_q, velocity_d;
    logic [31:0]        window_q, window_d;
    logic signed [31:0] index_pos_q, index_pos_d;
    logic signed [31:0] acc_q, acc_d;
    logic [31:0]        timer_q, timer_d;
    logic [31:0]        readdata_q, readdata_d;

    logic               en;
    logic [1:0]         delta;
    logic               legal_step;
    logic               illegal_step;
    logic signed [31:0] step;
    logic               z_rise;
    logic               wr;
    logic               rd;

    // Maps the {A,B} level pair to its position in the forward cycle
    // 00 -> 10 -> 11 -> 01, so a forward move is always +1 modulo 4.
    function automatic logic [1:0] phase(input logic a, input logic b);
        logic [1:0] p;
        case ({a, b})
            2'b00:   p = 2'd0;
            2'b10:   p = 2'd1;
            2'b11:   p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction

    assign avs_ctrl.waitrequest = 1'b0;
    assign avs_ctrl.readdata    = readdata_q;

    assign wr = avs_ctrl.write;
    assign rd = avs_ctrl.read & ~avs_ctrl.write;
    assign en = ctrl_q[0];

    // Two-flop synchroniser followed by a per-channel persistence filter.
    always_comb begin
        sync1_d = {enc_z, enc_b, enc_a};
        sync2_d = sync1_q;
        prev_d  = filt_q;
        filt_d  = filt_q;
        for (int i = 0; i < 3; i++) begin
            fcnt_d[i] = 8'd0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST)
                    filt_d[i] = sync2_q[i];
                else
                    fcnt_d[i] = fcnt_q[i] + 8'd1;
            end
        end
    end

    // Decode the filtered A/B pair against last cycle's pair into a signed step.
    always_comb begin
        delta        = phase(filt_q[0], filt_q[1]) - phase(prev_q[0], prev_q[1]);
        legal_step   = en && (delta == 2'd1 || delta == 2'd3);
        illegal_step = en && (delta == 2'd2);
        step         = 32'sd0;
        if (legal_step)
            step = ((delta == 2'd3) ^ ctrl_q[1]) ? -32'sd1 : 32'sd1;
        z_rise       = en && filt_q[2] && !prev_q[2];
    end

    // Register file, position/velocity update and registered read mux.
    always_comb begin
        position_d  = position_q;
        ctrl_d      = ctrl_q;
        dir_d       = dir_q;
        err_d       = err_q;
        idx_seen_d  = idx_seen_q;
        err_cnt_d   = err_cnt_q;
        velocity_d  = velocity_q;
        window_d    = window_q;
        index_pos_d = index_pos_q;
        acc_d       = acc_q;
        timer_d     = timer_q;
        readdata_d  = readdata_q;

        // Bus write beats index clear, which beats the decoded count.
        if (wr && avs_ctrl.address == 3'd0)
            position_d = be_merge(position_q, avs_ctrl.writedata, avs_ctrl.byteenable);
        else if (z_rise && ctrl_q[2])
            position_d = 32'sd0;
        else
            position_d = position_q + step;

        if (wr && avs_ctrl.address == 3'd1)
            ctrl_d = avs_ctrl.writedata[2:0];

        // Clears are applied before sets so a same-cycle event is not lost.
        if (wr && avs_ctrl.address == 3'd2) begin
            if (avs_ctrl.writedata[1]) err_d      = 1'b0;
            if (avs_ctrl.writedata[2]) idx_seen_d = 1'b0;
        end
        if (illegal_step) begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc16(err_cnt_q);
        end
        if (legal_step)
            dir_d = step[31];
        if (z_rise) begin
            index_pos_d = position_q;
            idx_seen_d  = 1'b1;
        end

        // Velocity window: the accumulator sees every decoded count,
        // independent of what happened to POSITION this cycle.
        if (wr && avs_ctrl.address == 3'd5) begin
            window_d = be_merge(window_q, avs_ctrl.writedata, avs_ctrl.byteenable);
            timer_d  = 32'd0;
            acc_d    = 32'sd0;
        end else if (window_q == 32'd0) begin
            timer_d = 32'd0;
            acc_d   = acc_q + step;
        end else if (timer_q == window_q - 32'd1) begin
            velocity_d = acc_q + step;
            acc_d      = 32'sd0;
            timer_d    = 32'd0;
        end else begin
            timer_d = timer_q + 32'd1;
            acc_d   = acc_q + step;
        end

        if (rd) begin
            case (avs_ctrl.address)
                3'd0:    readdata_d = position_q;
                3'd1:    readdata_d = {29'd0, ctrl_q};
                3'd2:    readdata_d = {29'd0, idx_seen_q, err_q, dir_q};
                3'd3:    readdata_d = {16'd0, err_cnt_q};
                3'd4:    readdata_d = velocity_q;
                3'd5:    readdata_d = window_q;
                3'd6:    readdata_d = index_pos_q;
                default: readdata_d = 32'd0;
            endcase
        end
    end

    // State registers; reset clears everything at once, including the input path.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            prev_q      <= '0;
            for (int i = 0; i < 3; i++) fcnt_q[i] <= 8'd0;
            position_q  <= '0;
            ctrl_q      <= '0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            idx_seen_q  <= 1'b0;
            err_cnt_q   <= '0;
            velocity_q  <= '0;
            window_q    <= '0;
            index_pos_q <= '0;
            acc_q       <= '0;
            timer_q     <= '0;
            readdata_q  <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            prev_q      <= prev_d;
            for (int i = 0; i < 3; i++) fcnt_q[i] <= fcnt_d[i];
            position_q  <= position_d;
            ctrl_q      <= ctrl_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            idx_seen_q  <= idx_seen_d;
            err_cnt_q   <= err_cnt_d;
            velocity_q  <= velocity_d;
            window_q    <= window_d;
            index_pos_q <= index_pos_d;
            acc_q       <= acc_d;
            timer_q     <= timer_d;
            readdata_q  <= readdata_d;
        end
    end

endmodule
